// File: rtl/seg_pkg.sv
// Shared seven-segment constants: active-high hex glyph table and display defaults.
package seg_pkg;

   localparam int unsigned DEFAULT_SCAN_DIV = 250000;

   // All segments dark, active-high form; output stages invert for active-low boards.
   localparam logic [7:0] SEG_BLANK = 8'h00;

   // Active-high {g,f,e,d,c,b,a} patterns for hex 0-F.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble + decimal point to active-high {dp,g,f,e,d,c,b,a}.
module seg_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   output logic [7:0] seg
);

   always_comb begin
      seg = {dp, HEX_SEG[nibble]};
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-atomic snapshot, blink,
// decimal points and leading-zero blanking; outputs registered.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int unsigned N_DIGITS   = 4,
   parameter int unsigned SCAN_DIV   = DEFAULT_SCAN_DIV,
   parameter int unsigned BLINK_DIV  = 20000000,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*N_DIGITS-1:0] digits,
   input  logic [N_DIGITS-1:0]   blink_mask,
   input  logic [N_DIGITS-1:0]   dp_mask,
   input  logic                  lz_suppress,
   output logic [7:0]            seg,
   output logic [N_DIGITS-1:0]   an,
   output logic                  frame_tick
);

   localparam int unsigned SCAN_W  = (SCAN_DIV > 1)  ? $clog2(SCAN_DIV)  : 1;
   localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int unsigned IDX_W   = (N_DIGITS > 1)  ? $clog2(N_DIGITS)  : 1;

   localparam logic [SCAN_W-1:0]   SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
   localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
   localparam logic [7:0]          SEG_POL    = {8{ACTIVE_LOW}};
   localparam logic [N_DIGITS-1:0] AN_POL     = {N_DIGITS{ACTIVE_LOW}};

   logic [SCAN_W-1:0]     scan_cnt;
   logic [BLINK_W-1:0]    blink_cnt;
   logic                  blink_phase;
   logic [IDX_W-1:0]      idx;

   logic [4*N_DIGITS-1:0] sh_digits;
   logic [N_DIGITS-1:0]   sh_blink;
   logic [N_DIGITS-1:0]   sh_dp;
   logic                  sh_lz;

   logic                  scan_tick;
   logic                  blink_wrap;
   logic                  last_digit;
   logic                  upper_zero;
   logic [N_DIGITS-1:0]   lz_blank;
   logic [N_DIGITS-1:0]   an_sel;
   logic [3:0]            cur_nibble;
   logic                  cur_dp;
   logic                  cur_blink;
   logic                  cur_lz;
   logic                  digit_dark;
   logic [7:0]            dec_seg;
   logic [N_DIGITS-1:0]   an_next;

   assign scan_tick  = (scan_cnt == SCAN_LAST);
   assign blink_wrap = (blink_cnt == BLINK_LAST);
   assign last_digit = (idx == IDX_LAST);

   // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
   always_comb begin
      upper_zero = 1'b1;
      lz_blank   = '0;
      for (int unsigned i = N_DIGITS - 1; i >= 1; i--) begin
         upper_zero  = upper_zero & (sh_digits[4*i +: 4] == 4'h0);
         lz_blank[i] = sh_lz & upper_zero;
      end
   end

   always_comb begin
      cur_nibble = 4'h0;
      cur_dp     = 1'b0;
      cur_blink  = 1'b0;
      cur_lz     = 1'b0;
      an_sel     = '0;
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
         if (IDX_W'(i) == idx) begin
            cur_nibble = sh_digits[4*i +: 4];
            cur_dp     = sh_dp[i];
            cur_blink  = sh_blink[i];
            cur_lz     = lz_blank[i];
            an_sel[i]  = 1'b1;
         end
      end
      digit_dark = (cur_blink & ~blink_phase) | cur_lz;
      an_next    = digit_dark ? '0 : an_sel;
   end

   seg_decode u_decode (
      .nibble (cur_nibble),
      .dp     (cur_dp & ~cur_lz),
      .seg    (dec_seg)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         scan_cnt    <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
         idx         <= '0;
         sh_digits   <= '0;
         sh_blink    <= '0;
         sh_dp       <= '0;
         sh_lz       <= 1'b0;
         seg         <= SEG_BLANK ^ SEG_POL;
         an          <= AN_POL;
         frame_tick  <= 1'b0;
      end else begin
         scan_cnt   <= scan_tick  ? '0 : scan_cnt + 1'b1;
         blink_cnt  <= blink_wrap ? '0 : blink_cnt + 1'b1;
         frame_tick <= scan_tick & last_digit;
         if (blink_wrap) begin
            blink_phase <= ~blink_phase;
         end
         if (scan_tick) begin
            seg <= dec_seg ^ SEG_POL;
            an  <= an_next ^ AN_POL;
            idx <= last_digit ? '0 : idx + 1'b1;
            // The last digit is drawn from the old shadow on the same edge the new frame is captured.
            if (last_digit) begin
               sh_digits <= digits;
               sh_blink  <= blink_mask;
               sh_dp     <= dp_mask;
               sh_lz     <= lz_suppress;
            end
         end
      end
   end

endmodule
